huffman_decoder: RTL and testbench



---
 rtl/huffman_decoder.sv | 125 ++++++++++++
 tb/tb_huffman_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Bit-serial decoder for a fixed, complete 32-symbol canonical prefix code.
// One code bit per clock; each symbol is presented with a one-cycle valid pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | out of reset, serial_i ignored, ready low
// ST_RUN  | ready high, one code bit sampled every clock, decodes back-to-back
module huffman_decoder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       serial_i,
  output logic [4:0] symbol_o,
  output logic       ready,
  output logic       valid
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [4:0]            symbol_q, symbol_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH:0]   code_w;
  logic [3:0]            len_w;
  logic                  done_w;
  logic [4:0]            dec_w;

  // acc only ever holds the bits of the code in progress, so everything above
  // the candidate length must be zero for a prefix match.
  always_comb begin
    code_w = {acc_q, serial_i};
    len_w  = cnt_q + 4'd1;
    done_w = 1'b0;
    dec_w  = 5'd0;
    case (len_w)
      4'd3: begin
        if (code_w[DATA_WIDTH:2] == '0) begin
          done_w = 1'b1;
          dec_w  = {3'b000, code_w[1:0]};
        end
      end
      4'd4: begin
        if (code_w[DATA_WIDTH:4] == '0 && code_w[3:2] == 2'b10) begin
          done_w = 1'b1;
          dec_w  = {3'b001, code_w[1:0]};
        end
      end
      4'd5: begin
        if (code_w[DATA_WIDTH:5] == '0 && code_w[4:2] == 3'b110) begin
          done_w = 1'b1;
          dec_w  = {3'b010, code_w[1:0]};
        end
      end
      4'd6: begin
        if (code_w[DATA_WIDTH:6] == '0 && code_w[5:2] == 4'b1110) begin
          done_w = 1'b1;
          dec_w  = {3'b011, code_w[1:0]};
        end
      end
      4'd8: begin
        if (code_w[DATA_WIDTH:8] == '0 && code_w[7:4] == 4'b1111) begin
          done_w = 1'b1;
          dec_w  = {1'b1, code_w[3:0]};
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    symbol_d = symbol_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (done_w) begin
          symbol_d = dec_w;
          valid_d  = 1'b1;
          acc_d    = '0;
          cnt_d    = 4'd0;
        end else begin
          acc_d = code_w[DATA_WIDTH-1:0];
          cnt_d = len_w;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_INIT;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      symbol_q <= 5'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      symbol_q <= symbol_d;
      valid_q  <= valid_d;
    end
  end

  assign symbol_o = symbol_q;
  assign valid    = valid_q;
  assign ready    = (state_q == ST_RUN);

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed table vectors plus hand sequences and a codebook model for the
// serial Huffman decoder.
module tb_huffman_decoder;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       serial_i;
  logic [4:0] symbol_o;
  logic       ready;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  huffman_decoder #(.DATA_WIDTH(8)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .serial_i (serial_i),
    .symbol_o (symbol_o),
    .ready    (ready),
    .valid    (valid)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] code;
    int         len;
    logic [4:0] sym;
  } vec_t;

  vec_t vecs[10];

  int code_val[32];
  int code_len[32];
  int m_val;
  int m_len;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic b, output logic hit, output logic [4:0] sym);
    m_val = m_val * 2 + int'(b);
    m_len++;
    hit   = 1'b0;
    sym   = 5'd0;
    for (int s = 0; s < 32; s++) begin
      if (code_len[s] == m_len && code_val[s] == m_val) begin
        hit = 1'b1;
        sym = 5'(s);
      end
    end
    if (hit) begin
      m_val = 0;
      m_len = 0;
    end
  endtask

  // Called at posedge+1; returns valid/symbol as seen just after the sampling edge.
  task automatic send_bit(input logic b, output logic v, output logic [4:0] s);
    check("ready_before_sample", int'(ready), 1);
    serial_i = b;
    @(posedge clk_i);
    #1;
    v = valid;
    s = symbol_o;
  endtask

  task automatic do_reset();
    rstn_i   = 1'b0;
    serial_i = 1'bx;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_symbol", int'(symbol_o), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ready", int'(ready), 0);
    rstn_i = 1'b1;
    #1;
    check("ready_low_before_edge", int'(ready), 0);
    @(posedge clk_i);
    #1;
    check("ready_after_release", int'(ready), 1);
    check("valid_after_release", int'(valid), 0);
    m_val = 0;
    m_len = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v;
    logic [4:0] s;
    logic [4:0] prev;
    logic       hit;
    logic [4:0] msym;
    logic [4:0] exp_sym;
    logic [9:0] seq10;
    logic [10:0] seq11;
    int         npulse;
    int         p1;
    int         p2;

    rstn_i   = 1'b0;
    serial_i = 1'b0;

    for (int s2 = 0; s2 < 32; s2++) begin
      if (s2 < 4) begin
        code_len[s2] = 3; code_val[s2] = s2;
      end else if (s2 < 8) begin
        code_len[s2] = 4; code_val[s2] = 8 + (s2 - 4);
      end else if (s2 < 12) begin
        code_len[s2] = 5; code_val[s2] = 24 + (s2 - 8);
      end else if (s2 < 16) begin
        code_len[s2] = 6; code_val[s2] = 56 + (s2 - 12);
      end else begin
        code_len[s2] = 8; code_val[s2] = 240 + (s2 - 16);
      end
    end

    vecs[0] = '{8'b00000000, 3, 5'd0};
    vecs[1] = '{8'b00000011, 3, 5'd3};
    vecs[2] = '{8'b00001000, 4, 5'd4};
    vecs[3] = '{8'b00001011, 4, 5'd7};
    vecs[4] = '{8'b00011001, 5, 5'd9};
    vecs[5] = '{8'b00111001, 6, 5'd13};
    vecs[6] = '{8'b11110000, 8, 5'd16};
    vecs[7] = '{8'b11111010, 8, 5'd26};
    vecs[8] = '{8'b00000001, 3, 5'd1};
    vecs[9] = '{8'b11111111, 8, 5'd31};

    // Reset values and INIT -> RUN
    do_reset();

    // Table vectors applied back-to-back
    prev = 5'd0;
    for (int i = 0; i < 10; i++) begin
      for (int k = vecs[i].len - 1; k >= 0; k--) begin
        send_bit(vecs[i].code[k], v, s);
        if (k > 0) begin
          check("vec_valid_low", int'(v), 0);
          check("vec_symbol_hold", int'(s), int'(prev));
        end else begin
          check("vec_valid_pulse", int'(v), 1);
          check("vec_symbol", int'(s), int'(vecs[i].sym));
        end
      end
      prev = vecs[i].sym;
    end

    // 0,1,0 -> 2, then valid drops
    do_reset();
    send_bit(1'b0, v, s); check("s010_b0_valid", int'(v), 0);
    send_bit(1'b1, v, s); check("s010_b1_valid", int'(v), 0);
    send_bit(1'b0, v, s); check("s010_valid", int'(v), 1);
    check("s010_symbol", int'(s), 2);
    send_bit(1'b1, v, s); check("s010_valid_drop", int'(v), 0);
    check("s010_symbol_hold", int'(s), 2);

    // 1011 then 111011: pulses at bit indices 3 and 9
    do_reset();
    seq10 = 10'b1011111011;
    npulse = 0; p1 = -1; p2 = -1;
    for (int k = 9; k >= 0; k--) begin
      send_bit(seq10[k], v, s);
      if (v) begin
        npulse++;
        if (npulse == 1) begin
          p1 = 9 - k;
          check("s7_symbol", int'(s), 7);
        end else begin
          p2 = 9 - k;
          check("s15_symbol", int'(s), 15);
        end
      end
    end
    check("s7_15_pulse_count", npulse, 2);
    check("s7_pulse_pos", p1, 3);
    check("s15_pulse_pos", p2, 9);

    // 8 ones then 000: 31, hold, then 0 with no gap
    do_reset();
    seq11 = 11'b11111111000;
    for (int k = 10; k >= 0; k--) begin
      send_bit(seq11[k], v, s);
      case (10 - k)
        7: begin
          check("s31_valid", int'(v), 1);
          check("s31_symbol", int'(s), 31);
        end
        8, 9: begin
          check("s31_gap_valid", int'(v), 0);
          check("s31_hold", int'(s), 31);
        end
        10: begin
          check("s0_valid", int'(v), 1);
          check("s0_symbol", int'(s), 0);
        end
        default: check("s31_prefix_valid", int'(v), 0);
      endcase
    end

    // Mid-code reset: decode 7, start 111, reset asynchronously, then 001 -> 1
    do_reset();
    send_bit(1'b1, v, s); send_bit(1'b0, v, s);
    send_bit(1'b1, v, s); send_bit(1'b1, v, s);
    check("mid_pre_symbol", int'(s), 7);
    for (int k = 0; k < 3; k++) begin
      send_bit(1'b1, v, s);
      check("mid_partial_valid", int'(v), 0);
    end
    rstn_i = 1'b0;
    #1;
    check("mid_async_symbol", int'(symbol_o), 0);
    check("mid_async_ready", int'(ready), 0);
    check("mid_async_valid", int'(valid), 0);
    do_reset();
    send_bit(1'b0, v, s); check("mid_after_b0", int'(v), 0);
    send_bit(1'b0, v, s); check("mid_after_b1", int'(v), 0);
    send_bit(1'b1, v, s);
    check("mid_after_valid", int'(v), 1);
    check("mid_after_symbol", int'(s), 1);

    // 400 random bits against the codebook model
    do_reset();
    exp_sym = 5'd0;
    for (int i = 0; i < 400; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      model_push(b, hit, msym);
      if (hit) exp_sym = msym;
      send_bit(b, v, s);
      check("rand_valid", int'(v), int'(hit));
      check("rand_symbol", int'(s), int'(exp_sym));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
